serial_add_ctrl: RTL

//  Bit-serial add/subtract sequencer built around one full_adder cell.

---
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around one full-adder cell
//
// Purpose:
//   Captures two WIDTH-bit operands on an accepted start and streams them
//   LSB-first through a single full-adder cell, one bit per clock, with the
//   inter-bit carry held in a flip-flop. Subtraction is a + ~b + 1: b is
//   inverted bit by bit and the carry flip-flop is preset to 1 at load.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, accepted only in IDLE or DONE
//   sub       0: a+b, 1: a-b (captured with start)
//   a, b      operands (captured with start)
//   busy      high while the operation is in flight
//   done      one-cycle pulse, result valid from this cycle on
//   sum       result, held until the next completion
//   cout      carry-out (add) / not-borrow (sub)
//   overflow  signed two's-complement overflow

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] psum;
  logic [CW-1:0]    cnt;
  logic             sub_q;
  logic             carry;

  // The single full-adder cell; b is inverted here for subtraction.
  logic fa_a;
  logic fa_b;
  logic fa_sum;
  logic fa_cout;

  always_comb begin
    fa_a    = sa[0];
    fa_b    = sb[0] ^ sub_q;
    fa_sum  = fa_a ^ fa_b ^ carry;
    fa_cout = (fa_a & fa_b) | (fa_a & carry) | (fa_b & carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      sa       <= '0;
      sb       <= '0;
      psum     <= '0;
      cnt      <= '0;
      sub_q    <= 1'b0;
      carry    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sub_q <= sub;
            carry <= sub;  // +1 of the two's-complement negate
            cnt   <= '0;
            psum  <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          carry <= fa_cout;
          psum  <= {fa_sum, psum[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum      <= {fa_sum, psum[WIDTH-1:1]};
            cout     <= fa_cout;
            // carry into the MSB differs from carry out of it
            overflow <= carry ^ fa_cout;
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
